// File: rtl/pflink_l1_pkg.sv
// Shared widths, header layout and reset constants for the PF-link L1 header path.
package pflink_l1_pkg;

  localparam int unsigned DEF_EVTID_W = 32;
  localparam int unsigned DEF_SPILL_W = 12;
  localparam int unsigned DEF_TIS_W   = 32;
  localparam int unsigned DEF_BXID_W  = 12;
  localparam int unsigned DROP_W      = 16;

  typedef struct packed {
    logic [DEF_EVTID_W-1:0] evtid;
    logic [DEF_SPILL_W-1:0] spill;
    logic [DEF_TIS_W-1:0]   timeinspill;
    logic [DEF_BXID_W-1:0]  bxid;
  } l1_header_t;

  localparam l1_header_t          HEADER_RST  = '0;
  localparam logic [DROP_W-1:0]   DROPPED_RST = '0;
  localparam logic [DROP_W-1:0]   DROPPED_MAX = '1;

endpackage

// File: rtl/l1_timebase.sv
// Spill counter plus prescaled, saturating time-in-spill counter.
module l1_timebase
  import pflink_l1_pkg::*;
#(
  parameter int unsigned SPILL_W      = DEF_SPILL_W,
  parameter int unsigned TIS_W        = DEF_TIS_W,
  parameter int unsigned TIS_PRESCALE = 5
) (
  input  logic               bx_clk,
  input  logic               reset_n,
  input  logic               newspill,
  output logic [SPILL_W-1:0] spill,
  output logic [SPILL_W-1:0] spill_cap,
  output logic [TIS_W-1:0]   tis_cap
);

  localparam int unsigned     PS_W    = (TIS_PRESCALE > 1) ? $clog2(TIS_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TIS_PRESCALE - 1);

  logic [PS_W-1:0]  presc_q;
  logic [TIS_W-1:0] tis_q;
  logic             wrap;

  assign wrap = (presc_q == PS_LAST);

  // Values an L1A in this cycle must record: a same-cycle newspill wins.
  assign spill_cap = newspill ? spill + SPILL_W'(1) : spill;
  assign tis_cap   = newspill ? '0 : tis_q;

  always_ff @(posedge bx_clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tis_q   <= '0;
      spill   <= '0;
    end else if (newspill) begin
      presc_q <= '0;
      tis_q   <= '0;
      spill   <= spill + SPILL_W'(1);
    end else begin
      presc_q <= wrap ? '0 : presc_q + PS_W'(1);
      if (wrap && (tis_q != '1)) begin
        tis_q <= tis_q + TIS_W'(1);
      end
    end
  end

endmodule

// File: rtl/l1_header_buffer.sv
// Show-ahead FIFO of L1 trigger headers with occupancy flags and drop accounting.
module l1_header_buffer
  import pflink_l1_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 8,
  parameter int unsigned EVTID_W      = DEF_EVTID_W,
  parameter int unsigned SPILL_W      = DEF_SPILL_W,
  parameter int unsigned TIS_W        = DEF_TIS_W,
  parameter int unsigned BXID_W       = DEF_BXID_W,
  parameter int unsigned TIS_PRESCALE = 5,
  parameter int unsigned AFULL_THRESH = 2**DEPTH_LOG2 - 4
) (
  input  logic                  bx_clk,
  input  logic                  reset_n,
  input  logic                  l1a,
  input  logic                  newspill,
  input  logic [BXID_W-1:0]     bxid,
  input  logic                  advance,
  output logic                  tag_valid,
  output logic [EVTID_W-1:0]    tag_evtid,
  output logic [SPILL_W-1:0]    tag_spill,
  output logic [TIS_W-1:0]      tag_timeinspill,
  output logic [BXID_W-1:0]     tag_bxid,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic                  full,
  output logic                  busy,
  output logic [EVTID_W-1:0]    evtid,
  output logic [SPILL_W-1:0]    spill,
  output logic [DROP_W-1:0]     dropped
);

  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned HDR_W = EVTID_W + SPILL_W + TIS_W + BXID_W;

  logic [SPILL_W-1:0] spill_cap;
  logic [TIS_W-1:0]   tis_cap;

  l1_timebase #(
    .SPILL_W      (SPILL_W),
    .TIS_W        (TIS_W),
    .TIS_PRESCALE (TIS_PRESCALE)
  ) u_timebase (
    .bx_clk    (bx_clk),
    .reset_n   (reset_n),
    .newspill  (newspill),
    .spill     (spill),
    .spill_cap (spill_cap),
    .tis_cap   (tis_cap)
  );

  logic [HDR_W-1:0] mem [DEPTH];
  logic [HDR_W-1:0] wdata;
  logic [HDR_W-1:0] tag_q;
  logic [PTR_W-1:0] wptr_q, rptr_q, wptr_d, rptr_d, occ_d;
  logic             push, pop, bypass;

  assign wdata = {evtid, spill_cap, tis_cap, bxid};
  assign pop   = advance & tag_valid;
  assign push  = l1a & (~full | pop);

  always_comb begin
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
    occ_d  = wptr_d - rptr_d;
    // The entry being written this edge becomes the new head: forward it past the RAM.
    bypass = push && (wptr_q == rptr_d);
  end

  always_ff @(posedge bx_clk) begin
    if (push) begin
      mem[wptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge bx_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      tag_q     <= '0;
      tag_valid <= 1'b0;
      occupancy <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      evtid     <= '0;
      dropped   <= DROPPED_RST;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      tag_q     <= bypass ? wdata : mem[rptr_d[AW-1:0]];
      tag_valid <= (occ_d != '0);
      occupancy <= occ_d;
      full      <= (occ_d == PTR_W'(DEPTH));
      busy      <= (occ_d >= PTR_W'(AFULL_THRESH));
      if (l1a) begin
        evtid <= evtid + EVTID_W'(1);
      end
      if (l1a && !push && (dropped != DROPPED_MAX)) begin
        dropped <= dropped + DROP_W'(1);
      end
    end
  end

  assign tag_bxid        = tag_q[BXID_W-1:0];
  assign tag_timeinspill = tag_q[BXID_W +: TIS_W];
  assign tag_spill       = tag_q[BXID_W+TIS_W +: SPILL_W];
  assign tag_evtid       = tag_q[BXID_W+TIS_W+SPILL_W +: EVTID_W];

endmodule

// File: tb/tb_l1_header_buffer.sv
// Self-checking bench for l1_header_buffer: directed tables, corner sequences, random vs model.
module tb_l1_header_buffer;
  import pflink_l1_pkg::*;

  localparam int unsigned DEPTH     = 256;
  localparam int unsigned PRESCALE  = 5;
  localparam int unsigned THRESH    = 252;

  logic        bx_clk;
  logic        reset_n;
  logic        l1a, newspill, advance;
  logic [11:0] bxid;
  logic        tag_valid;
  logic [31:0] tag_evtid;
  logic [11:0] tag_spill;
  logic [31:0] tag_timeinspill;
  logic [11:0] tag_bxid;
  logic [8:0]  occupancy;
  logic        full, busy;
  logic [31:0] evtid;
  logic [11:0] spill;
  logic [15:0] dropped;

  l1_header_buffer #(
    .DEPTH_LOG2   (8),
    .EVTID_W      (32),
    .SPILL_W      (12),
    .TIS_W        (32),
    .BXID_W       (12),
    .TIS_PRESCALE (PRESCALE),
    .AFULL_THRESH (THRESH)
  ) dut (
    .bx_clk          (bx_clk),
    .reset_n         (reset_n),
    .l1a             (l1a),
    .newspill        (newspill),
    .bxid            (bxid),
    .advance         (advance),
    .tag_valid       (tag_valid),
    .tag_evtid       (tag_evtid),
    .tag_spill       (tag_spill),
    .tag_timeinspill (tag_timeinspill),
    .tag_bxid        (tag_bxid),
    .occupancy       (occupancy),
    .full            (full),
    .busy            (busy),
    .evtid           (evtid),
    .spill           (spill),
    .dropped         (dropped)
  );

  initial bx_clk = 1'b0;
  always #5 bx_clk = ~bx_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of headers plus plain counters.
  l1_header_t  q[$];
  logic [31:0] m_evtid;
  logic [11:0] m_spill;
  int unsigned m_since;
  int unsigned m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_evtid = '0;
    m_spill = '0;
    m_since = 0;
    m_drop  = 0;
  endtask

  task automatic model_step(input logic a_l1a, input logic a_ns, input logic [11:0] a_bx,
                            input logic a_adv);
    l1_header_t h;
    bit do_pop, room;
    do_pop = a_adv && (q.size() != 0);
    room   = (q.size() < DEPTH) || do_pop;
    h.evtid       = m_evtid;
    h.spill       = a_ns ? m_spill + 12'd1 : m_spill;
    h.timeinspill = a_ns ? 32'd0 : 32'(m_since / PRESCALE);
    h.bxid        = a_bx;
    if (do_pop) void'(q.pop_front());
    if (a_l1a) begin
      if (room) q.push_back(h);
      else if (m_drop < 65535) m_drop++;
      m_evtid++;
    end
    if (a_ns) begin
      m_spill++;
      m_since = 0;
    end else begin
      m_since++;
    end
  endtask

  task automatic check_model();
    chk("tag_valid", 64'(tag_valid), 64'(q.size() != 0));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("busy", 64'(busy), 64'(q.size() >= THRESH));
    chk("evtid", 64'(evtid), 64'(m_evtid));
    chk("spill", 64'(spill), 64'(m_spill));
    chk("dropped", 64'(dropped), 64'(m_drop));
    if (q.size() != 0) begin
      chk("tag_evtid", 64'(tag_evtid), 64'(q[0].evtid));
      chk("tag_spill", 64'(tag_spill), 64'(q[0].spill));
      chk("tag_tis", 64'(tag_timeinspill), 64'(q[0].timeinspill));
      chk("tag_bxid", 64'(tag_bxid), 64'(q[0].bxid));
    end
  endtask

  task automatic cycle(input logic a_l1a, input logic a_ns, input logic [11:0] a_bx,
                       input logic a_adv);
    l1a      = a_l1a;
    newspill = a_ns;
    bxid     = a_bx;
    advance  = a_adv;
    @(posedge bx_clk);
    model_step(a_l1a, a_ns, a_bx, a_adv);
    #1;
    l1a      = 1'b0;
    newspill = 1'b0;
    advance  = 1'b0;
    check_model();
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_tag_valid", 64'(tag_valid), 64'd0);
    chk("rst_tag_evtid", 64'(tag_evtid), 64'd0);
    chk("rst_tag_spill", 64'(tag_spill), 64'd0);
    chk("rst_tag_tis", 64'(tag_timeinspill), 64'd0);
    chk("rst_tag_bxid", 64'(tag_bxid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_evtid", 64'(evtid), 64'd0);
    chk("rst_spill", 64'(spill), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    @(negedge bx_clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        l1a, ns, adv;
    logic [11:0] bx;
    logic        exp_valid;
    logic [31:0] exp_evtid;
    logic [11:0] exp_bxid;
    logic [8:0]  exp_occ;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset_n  = 1'b0;
    l1a      = 1'b0;
    newspill = 1'b0;
    advance  = 1'b0;
    bxid     = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 12'h010, 1'b1, 32'd0, 12'h010, 9'd1, 32'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 12'h020, 1'b1, 32'd0, 12'h010, 9'd2, 32'd2};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 12'h030, 1'b1, 32'd0, 12'h010, 9'd3, 32'd3};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 32'd1, 12'h020, 9'd2, 32'd3};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 32'd2, 12'h030, 9'd1, 32'd3};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 32'd0, 12'h000, 9'd0, 32'd3};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 32'd0, 12'h000, 9'd0, 32'd3};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 12'h040, 1'b1, 32'd3, 12'h040, 9'd1, 32'd4};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 12'h050, 1'b1, 32'd4, 12'h050, 9'd1, 32'd5};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 32'd0, 12'h000, 9'd0, 32'd5};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].l1a, vecs[i].ns, vecs[i].bx, vecs[i].adv);
      chk($sformatf("vec%0d_valid", i), 64'(tag_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      chk($sformatf("vec%0d_evtid_cnt", i), 64'(evtid), 64'(vecs[i].exp_cnt));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_tag_evtid", i), 64'(tag_evtid), 64'(vecs[i].exp_evtid));
        chk($sformatf("vec%0d_tag_bxid", i), 64'(tag_bxid), 64'(vecs[i].exp_bxid));
      end
    end

    // Spill and time base.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 12'h000, 1'b0);
    chk("spill_is_4", 64'(spill), 64'd4);
    cycle(1'b1, 1'b1, 12'h0AA, 1'b0);
    chk("ns_l1a_spill", 64'(tag_spill), 64'd5);
    chk("ns_l1a_tis", 64'(tag_timeinspill), 64'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 12'h000, 1'b0);
    cycle(1'b1, 1'b0, 12'h0BB, 1'b0);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    chk("tis_after_10", 64'(tag_timeinspill), 64'd2);
    chk("tis_entry_bxid", 64'(tag_bxid), 64'h0BB);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Pointer wrap with alternating push and pop.
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1, 1'b0, 12'(i), 1'b0);
      chk("wrap_occ_le1", 64'(occupancy <= 9'd1), 64'd1);
      cycle(1'b0, 1'b0, 12'h000, 1'b1);
      chk("wrap_occ_le1", 64'(occupancy <= 9'd1), 64'd1);
    end

    // Fill to full, overflow, then push+pop while full and drain.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 1'b0, 12'(i), 1'b0);
      if (i == 250) chk("busy_at_251", 64'(busy), 64'd0);
      if (i == 251) chk("busy_at_252", 64'(busy), 64'd1);
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_occ", 64'(occupancy), 64'd256);
    cycle(1'b1, 1'b0, 12'h777, 1'b0);
    cycle(1'b1, 1'b0, 12'h778, 1'b0);
    chk("ovf_dropped", 64'(dropped), 64'd2);
    chk("ovf_evtid", 64'(evtid), 64'd258);
    chk("ovf_head", 64'(tag_evtid), 64'd0);
    cycle(1'b1, 1'b0, 12'h999, 1'b1);
    chk("full_pushpop_occ", 64'(occupancy), 64'd256);
    chk("full_pushpop_drop", 64'(dropped), 64'd2);
    for (int i = 1; i <= 255; i++) begin
      cycle(1'b0, 1'b0, 12'h000, 1'b1);
      if (i == 4) chk("drain_busy_252", 64'(busy), 64'd1);
      if (i == 5) chk("drain_busy_251", 64'(busy), 64'd0);
    end
    chk("next_accepted_evtid", 64'(tag_evtid), 64'd258);
    chk("next_accepted_bxid", 64'(tag_bxid), 64'h999);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Randomised traffic: a filling phase (drops likely) then a draining phase.
    for (int i = 0; i < 3000; i++) begin
      int unsigned pl, pa;
      pl = (i < 1500) ? 70 : 30;
      pa = (i < 1500) ? 30 : 70;
      cycle(1'($urandom_range(99) < pl), 1'($urandom_range(99) < 2), 12'($urandom),
            1'($urandom_range(99) < pa));
    end

    // Reset mid-stream, then the first L1A must carry evtid 0.
    cycle(1'b1, 1'b0, 12'h321, 1'b0);
    do_reset();
    cycle(1'b1, 1'b0, 12'h123, 1'b0);
    chk("post_reset_evtid", 64'(tag_evtid), 64'd0);
    chk("post_reset_bxid", 64'(tag_bxid), 64'h123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
